// File: rtl/fuzzy_sample_ctrl.sv
// fuzzy_sample_ctrl
// Sequencer between a valid/ready sample stream and the type-2 fuzzy core.
// Each accepted (e1, e2) pair is latched onto the core inputs. EN_REGRAS is
// held while N_RULES rule strobes are counted on Sclk_int. The block then
// waits SETTLE cycles for the defuzzifier and captures saida_defuzzy into a
// one-deep valid/ready output buffer. A RUN phase that sees too few strobes
// within TIMEOUT cycles is aborted, and the abort sets a sticky error flag.

module fuzzy_sample_ctrl #(
  parameter int unsigned N_RULES = 9,     // Sclk_int rises per inference
  parameter int unsigned SETTLE  = 4,     // cycles after last rule, >= 1
  parameter int unsigned TIMEOUT = 1023,  // max RUN cycles before abort
  parameter int unsigned CNT_W   = 10     // counter width, must hold TIMEOUT
) (
  input  logic       clk_0,
  input  logic       Srst,           // asynchronous, active low

  // sample stream
  input  logic       sample_valid,
  output logic       sample_ready,
  input  logic [7:0] sample_e1,
  input  logic [7:0] sample_e2,

  // fuzzy core interface
  output logic [7:0] Entrada_01,
  output logic [7:0] Entrada_02,
  output logic       EN_REGRAS,
  input  logic       Sclk_int,
  input  logic [7:0] saida_defuzzy,

  // result stream
  output logic       result_valid,
  input  logic       result_ready,
  output logic [7:0] result_data,

  // status
  output logic       busy,
  output logic       timeout_err,
  input  logic       err_clr
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_SETTLE   = 2'd2,
    S_WAIT_OUT = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] LP_N_RULES     = CNT_W'(N_RULES);
  localparam logic [CNT_W-1:0] LP_TIMEOUT     = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LP_SETTLE_LAST = CNT_W'(SETTLE - 1);

  // registers
  state_e           r_state;
  logic             r_sclk_q;
  logic [CNT_W-1:0] r_rule_cnt;
  logic [CNT_W-1:0] r_cyc_cnt;
  logic [7:0]       r_entrada_01;
  logic [7:0]       r_entrada_02;
  logic             r_result_valid;
  logic [7:0]       r_result_data;
  logic             r_timeout_err;

  // combinational control
  state_e           w_state_nxt;
  logic [CNT_W-1:0] w_rule_nxt;
  logic [CNT_W-1:0] w_cyc_nxt;
  logic [CNT_W-1:0] w_rule_inc;
  logic [CNT_W-1:0] w_cyc_inc;
  logic             w_rise;
  logic             w_can_load;
  logic             w_accept;
  logic             w_capture;
  logic             w_to_set;

  // Rising edge of the core's rule strobe; only acted on while in RUN.
  assign w_rise     = Sclk_int & ~r_sclk_q;
  assign w_rule_inc = r_rule_cnt + CNT_W'(1);
  assign w_cyc_inc  = r_cyc_cnt + CNT_W'(1);

  // The buffer can take a new result if it is empty or drains this cycle.
  assign w_can_load = ~r_result_valid | result_ready;

  assign sample_ready = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign EN_REGRAS    = (r_state == S_RUN);

  assign Entrada_01   = r_entrada_01;
  assign Entrada_02   = r_entrada_02;
  assign result_valid = r_result_valid;
  assign result_data  = r_result_data;
  assign timeout_err  = r_timeout_err;

  // State register.
  // NOTE: all sequential state uses non-blocking assignments so every
  // register updates from pre-edge values regardless of block ordering.
  always_ff @(posedge clk_0 or negedge Srst) begin
    if (!Srst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state, counter updates and load strobes.
  // NOTE: every signal gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_rule_nxt  = r_rule_cnt;
    w_cyc_nxt   = r_cyc_cnt;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_to_set    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (sample_valid) begin
          w_accept    = 1'b1;
          w_rule_nxt  = '0;
          w_cyc_nxt   = '0;
          w_state_nxt = S_RUN;
        end
      end

      S_RUN: begin
        if (w_rise) w_rule_nxt = w_rule_inc;
        // The final rule strobe takes priority over a coincident timeout.
        if (w_rise && (w_rule_inc == LP_N_RULES)) begin
          w_cyc_nxt   = '0;
          w_state_nxt = S_SETTLE;
        end else begin
          w_cyc_nxt = w_cyc_inc;
          if (w_cyc_inc == LP_TIMEOUT) begin
            w_to_set    = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end

      S_SETTLE: begin
        if (r_cyc_cnt == LP_SETTLE_LAST) begin
          if (w_can_load) begin
            w_capture   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_WAIT_OUT;
          end
        end else begin
          w_cyc_nxt = w_cyc_inc;
        end
      end

      S_WAIT_OUT: begin
        if (w_can_load) begin
          w_capture   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Delayed copy of the rule strobe for edge detection, sampled every cycle.
  always_ff @(posedge clk_0 or negedge Srst) begin
    if (!Srst) r_sclk_q <= 1'b0;
    else       r_sclk_q <= Sclk_int;
  end

  // Rule and cycle counters.
  always_ff @(posedge clk_0 or negedge Srst) begin
    if (!Srst) begin
      r_rule_cnt <= '0;
      r_cyc_cnt  <= '0;
    end else begin
      r_rule_cnt <= w_rule_nxt;
      r_cyc_cnt  <= w_cyc_nxt;
    end
  end

  // Core inputs change only on an accepted sample, so they stay stable
  // from RUN through capture.
  always_ff @(posedge clk_0 or negedge Srst) begin
    if (!Srst) begin
      r_entrada_01 <= '0;
      r_entrada_02 <= '0;
    end else if (w_accept) begin
      r_entrada_01 <= sample_e1;
      r_entrada_02 <= sample_e2;
    end
  end

  // One-deep output buffer; a capture in the drain cycle keeps valid high.
  // NOTE: the data register is reset as well, so nothing stale is visible
  // on result_data after reset.
  always_ff @(posedge clk_0 or negedge Srst) begin
    if (!Srst) begin
      r_result_valid <= 1'b0;
      r_result_data  <= '0;
    end else if (w_capture) begin
      r_result_valid <= 1'b1;
      r_result_data  <= saida_defuzzy;
    end else if (r_result_valid && result_ready) begin
      r_result_valid <= 1'b0;
    end
  end

  // Sticky timeout flag; a new abort beats a coincident clear.
  always_ff @(posedge clk_0 or negedge Srst) begin
    if (!Srst)         r_timeout_err <= 1'b0;
    else if (w_to_set) r_timeout_err <= 1'b1;
    else if (err_clr)  r_timeout_err <= 1'b0;
  end

endmodule
